// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a framed firmware image from the UART receiver and writes it into
//   RAM. Bytes are assembled into DATA_W words, either big or little endian.
//   Each word goes to the next RAM address. The core is held in reset until
//   the whole image has been written.
//
//   Frame layout: 0xA5, LEN[7:0], LEN[15:8], then LEN*DATA_W/8 data bytes.
//   LEN is a count of words.
//
//   Optional feature (macro BOOT_CHECKSUM_EN): the frame ends with one more
//   byte, the sum of all data bytes mod 256. A mismatch ends in ERROR with
//   code 4. This happens only after the final write has completed.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   rx_data_i/rx_valid_i  byte stream from uart_rx (no backpressure)
//   mem_we_o/addr/wdata   RAM write request, held stable until mem_ready_i
//   mem_ready_i           write completes on an edge with mem_we_o & mem_ready_i
//   core_rst_o            core reset hold, low only in DONE
//   busy_o/done_o/err_o   status; err_code_o: 1 len, 2 timeout, 3 overrun, 4 csum
module uart_boot_loader #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                BIG_ENDIAN  = 1,
  parameter int                MAX_WORDS   = 4096,
  parameter int                TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        err_code_o
);

  localparam int BPW = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA,
`ifdef BOOT_CHECKSUM_EN
    CSUM,
`endif
    DRAIN, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       wcnt_q, wcnt_d;   // words assembled so far
  logic [3:0]        bcnt_q, bcnt_d;   // byte position within the current word
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [15:0]       idx_q, idx_d;     // writes completed
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       timer_q, timer_d;
  logic [2:0]        code_q, code_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_bad_q, csum_bad_d;
`endif

  logic              wr_done, counting, tmo;
  logic [15:0]       len_full, idx_eff;
  logic [DATA_W-1:0] asm_next;
  logic [ADDR_W-1:0] word_addr;

  assign wr_done  = we_q & mem_ready_i;
  assign len_full = {rx_data_i, len_q[7:0]};
  // A write that completes on this edge frees the holding register in time
  // for a new word. The new word's index must then include that completion.
  assign idx_eff  = idx_q + {15'd0, wr_done};
  assign word_addr = BASE_ADDR + ADDR_W'(idx_eff) * ADDR_W'(BPW);
  assign asm_next = (BIG_ENDIAN != 0)
                  ? ((asm_q << 8) | DATA_W'(rx_data_i))
                  : ((asm_q >> 8) | (DATA_W'(rx_data_i) << (DATA_W - 8)));

`ifdef BOOT_CHECKSUM_EN
  assign counting = (state_q == LEN0) | (state_q == LEN1) | (state_q == DATA) |
                    (state_q == CSUM);
`else
  assign counting = (state_q == LEN0) | (state_q == LEN1) | (state_q == DATA);
`endif
  // A byte arriving on the expiry cycle wins and restarts the timer.
  assign tmo = (TIMEOUT_CYC > 0) && counting && !rx_valid_i &&
               (timer_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer_q <= '0;
      code_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= '0;
      csum_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      code_q  <= code_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= csum_d;
      csum_bad_q <= csum_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    code_d  = code_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d     = csum_q;
    csum_bad_d = csum_bad_q;
`endif
    timer_d = (rx_valid_i || !counting) ? 32'd0 : timer_q + 32'd1;

    if (wr_done) begin
      we_d  = 1'b0;
      idx_d = idx_q + 16'd1;
    end

    unique case (state_q)
      IDLE: if (rx_valid_i && rx_data_i == 8'hA5) state_d = LEN0;
      LEN0: if (rx_valid_i) begin
        len_d[7:0] = rx_data_i;
        state_d    = LEN1;
      end
      LEN1: if (rx_valid_i) begin
        len_d = len_full;
        if (int'(len_full) > MAX_WORDS) begin
          state_d = ERROR;
          code_d  = 3'd1;
        end else if (len_full == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (rx_valid_i) begin
        asm_d = asm_next;
`ifdef BOOT_CHECKSUM_EN
        csum_d = csum_q + rx_data_i;
`endif
        if (bcnt_q == 4'(BPW - 1)) begin
          bcnt_d = '0;
          if (we_q && !mem_ready_i) begin
            // Holding register still occupied: drop the pending write.
            state_d = ERROR;
            code_d  = 3'd3;
            we_d    = 1'b0;
          end else begin
            we_d    = 1'b1;
            wdata_d = asm_next;
            addr_d  = word_addr;
            wcnt_d  = wcnt_q + 16'd1;
            if (wcnt_q == len_q - 16'd1) begin
`ifdef BOOT_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = DRAIN;
`endif
            end
          end
        end else begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: if (rx_valid_i) begin
        csum_bad_d = (rx_data_i != csum_q);
        state_d    = DRAIN;
      end
`endif
      DRAIN: if (!we_q || mem_ready_i) begin
`ifdef BOOT_CHECKSUM_EN
        if (csum_bad_q) begin
          state_d = ERROR;
          code_d  = 3'd4;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      DONE: ;
      ERROR: begin
        we_d = 1'b0;
        if (rx_valid_i && rx_data_i == 8'hA5) begin
          state_d = LEN0;
          code_d  = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
          asm_d   = '0;
          idx_d   = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_d     = '0;
          csum_bad_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo) begin
      state_d = ERROR;
      code_d  = 3'd2;
      we_d    = 1'b0;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign core_rst_o  = (state_q != DONE);
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == ERROR);
  assign busy_o      = counting | (state_q == DRAIN);
  assign err_code_o  = code_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        ready = 1'b0;
  bit          hold_rdy = 1'b0;

  logic        be_we, be_crst, be_busy, be_done, be_err;
  logic [31:0] be_addr, be_wdata;
  logic [2:0]  be_code;
  logic        le_we, le_crst, le_busy, le_done, le_err;
  logic [31:0] le_addr, le_wdata;
  logic [2:0]  le_code;

  int checks = 0, failures = 0;
  logic [7:0]  tx[$], dat[$];
  logic [31:0] qa_be[$], qd_be[$], qa_le[$], qd_le[$];

  always #5 clk = ~clk;

  uart_boot_loader #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .BIG_ENDIAN(1),
                     .MAX_WORDS(4096), .TIMEOUT_CYC(100)) u_be (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .mem_we_o(be_we), .mem_addr_o(be_addr), .mem_wdata_o(be_wdata), .mem_ready_i(ready),
    .core_rst_o(be_crst), .busy_o(be_busy), .done_o(be_done), .err_o(be_err),
    .err_code_o(be_code));

  uart_boot_loader #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h100), .BIG_ENDIAN(0),
                     .MAX_WORDS(4096), .TIMEOUT_CYC(0)) u_le (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .mem_we_o(le_we), .mem_addr_o(le_addr), .mem_wdata_o(le_wdata), .mem_ready_i(ready),
    .core_rst_o(le_crst), .busy_o(le_busy), .done_o(le_done), .err_o(le_err),
    .err_code_o(le_code));

  // RAM model: random-latency ready, changed well after the clock edge
  always begin
    @(posedge clk);
    #2 ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Writes that will complete on the next posedge
  always @(negedge clk) begin
    if (be_we && ready) begin qa_be.push_back(be_addr); qd_be.push_back(be_wdata); end
    if (le_we && ready) begin qa_le.push_back(le_addr); qd_le.push_back(le_wdata); end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_q();
    qa_be.delete(); qd_be.delete(); qa_le.delete(); qd_le.delete();
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_tx();
    foreach (tx[i]) begin
      strobe(tx[i]);
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
  endtask

  // Frame for the words in dat; csum_adj corrupts the trailing checksum
  task automatic build_frame(input int n, input int csum_adj);
    int s = 0;
    tx.delete();
    tx.push_back(8'hA5); tx.push_back(8'(n)); tx.push_back(8'(n >> 8));
    foreach (dat[i]) begin tx.push_back(dat[i]); s += int'(dat[i]); end
`ifdef BOOT_CHECKSUM_EN
    tx.push_back(8'(s + csum_adj));
`endif
  endtask

  task automatic rand_dat(input int nbytes);
    dat.delete();
    for (int i = 0; i < nbytes; i++) dat.push_back(8'($urandom_range(0, 255)));
  endtask

  // Word k of the image: byte i is weighted 256^(3-i) big endian, 256^i little
  function automatic logic [31:0] mword(input int k, input bit be);
    longint w = 0;
    for (int i = 0; i < 4; i++)
      w += longint'(dat[4*k+i]) * (longint'(1) << (8 * (be ? 3 - i : i)));
    return 32'(w);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_be_ctl"}, 64'({be_we, be_crst, be_busy, be_done, be_err, be_code}), 64'h40);
    chk({tag, "_be_bus"}, {be_addr, be_wdata}, 64'd0);
    chk({tag, "_le_ctl"}, 64'({le_we, le_crst, le_busy, le_done, le_err, le_code}), 64'h40);
    chk({tag, "_le_bus"}, {le_addr, le_wdata}, 64'd0);
  endtask

  // status vector {core_rst, busy, done, err, code}
  task automatic expect_done(input string tag);
    chk({tag, "_be_done"}, 64'({be_crst, be_busy, be_done, be_err, be_code}), 64'h10);
    chk({tag, "_le_done"}, 64'({le_crst, le_busy, le_done, le_err, le_code}), 64'h10);
  endtask

  task automatic expect_err(input string tag, input logic [2:0] c);
    chk({tag, "_be_err"}, 64'({be_crst, be_busy, be_done, be_err, be_code}), 64'({4'b1001, c}));
    chk({tag, "_le_err"}, 64'({le_crst, le_busy, le_done, le_err, le_code}), 64'({4'b1001, c}));
  endtask

  task automatic wait_settle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ((be_done || be_err) && (le_done || le_err)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_settle"}, 64'(ok), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr_be"}, 64'(qa_be.size()), 64'(n));
    chk({tag, "_nwr_le"}, 64'(qa_le.size()), 64'(n));
    for (int k = 0; k < n && k < qa_be.size() && k < qa_le.size(); k++) begin
      chk($sformatf("%s_be_w%0d", tag, k), {qa_be[k], qd_be[k]}, {32'(4 * k), mword(k, 1'b1)});
      chk($sformatf("%s_le_w%0d", tag, k), {qa_le[k], qd_le[k]},
          {32'(32'h100 + 4 * k), mword(k, 1'b0)});
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clr_q();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset("rst_held");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_idle");

    // Directed image with known words
    dat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    build_frame(2, 0); send_tx(); wait_settle("t1");
    expect_done("t1");
    check_writes("t1", 2);
    chk("t1_be_lit", {qd_be[0], qd_be[1]}, 64'hDEADBEEF_01020304);
    chk("t1_le_lit", {qd_le[0], qd_le[1]}, 64'hEFBEADDE_04030201);

    // DONE ignores further traffic
    clr_q();
    dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_frame(1, 0); send_tx(); repeat (10) @(negedge clk);
    chk("done_nowr", 64'(qa_be.size() + qa_le.size()), 64'd0);
    expect_done("done_hold");

    // Oversized length, then restart from ERROR
    pulse_reset();
    tx = '{8'hA5, 8'h00, 8'h20}; send_tx(); repeat (3) @(negedge clk);
    expect_err("len", 3'd1);
    chk("len_nowr", 64'(qa_be.size() + qa_le.size()), 64'd0);
    rand_dat(4); build_frame(1, 0); send_tx(); wait_settle("rec");
    expect_done("rec"); check_writes("rec", 1);

    // Zero-length image
    pulse_reset();
    dat.delete(); build_frame(0, 0); send_tx(); wait_settle("len0");
    expect_done("len0");
    chk("len0_nowr", 64'(qa_be.size() + qa_le.size()), 64'd0);

    // Random images behind random pre-frame junk
    for (int it = 0; it < 4; it++) begin
      pulse_reset();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j = 8'($urandom_range(0, 255));
        strobe(j == 8'hA5 ? 8'h5A : j);
      end
      n = $urandom_range(1, 6);
      rand_dat(4 * n); build_frame(n, 0); send_tx(); wait_settle($sformatf("rnd%0d", it));
      expect_done($sformatf("rnd%0d", it));
      check_writes($sformatf("rnd%0d", it), n);
    end

    // Overrun: RAM never ready while a second word completes
    pulse_reset();
    hold_rdy = 1'b1;
    rand_dat(8); tx = '{8'hA5, 8'h03, 8'h00}; foreach (dat[i]) tx.push_back(dat[i]);
    send_tx();
    expect_err("ovr", 3'd3);
    chk("ovr_we", 64'({be_we, le_we}), 64'd0);
    hold_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovr_nowr", 64'(qa_be.size() + qa_le.size()), 64'd0);
    rand_dat(4); build_frame(1, 0); send_tx(); wait_settle("ovr_rec");
    expect_done("ovr_rec"); check_writes("ovr_rec", 1);

    // Timeout on the big-endian instance: error exactly 100 cycles after last byte
    pulse_reset();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34}; send_tx();
    strobe(8'h56);
    repeat (99) @(negedge clk);
    chk("tmo_early", 64'({be_busy, be_err}), 64'b10);
    @(negedge clk);
    chk("tmo_fire", 64'({be_crst, be_busy, be_done, be_err, be_code}), 64'({4'b1001, 3'd2}));
    chk("tmo_le_busy", 64'({le_busy, le_err}), 64'b10);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: image still written, then ERROR 4, never DONE
    pulse_reset();
    rand_dat(8); build_frame(2, 1); send_tx(); wait_settle("csum");
    expect_err("csum", 3'd4);
    check_writes("csum", 2);
`endif

    // Reset in the middle of DATA, then a fresh image
    pulse_reset();
    rand_dat(5); tx = '{8'hA5, 8'h02, 8'h00}; foreach (dat[i]) tx.push_back(dat[i]);
    send_tx();
    @(negedge clk); rst = 1'b1;
    #1 chk_reset("mid_rst");
    @(negedge clk); rst = 1'b0; clr_q();
    rand_dat(12); build_frame(3, 0); send_tx(); wait_settle("fresh");
    expect_done("fresh"); check_writes("fresh", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
